forward_hazard_unit: RTL and testbench



---
 rtl/mips_pipe_pkg.sv | 23 ++
 rtl/fwd_compare.sv | 21 ++
 rtl/forward_hazard_unit.sv | 61 ++++++
 tb/tb_forward_hazard_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared forwarding-select constants and stage-tracking records
package mips_pipe_pkg;
  localparam int REG_ADDR_W_DEFAULT = 5;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  typedef struct packed {
    logic [REG_ADDR_W_DEFAULT-1:0] rs;
    logic [REG_ADDR_W_DEFAULT-1:0] rt;
    logic [REG_ADDR_W_DEFAULT-1:0] dst;
    logic reg_write;
    logic mem_read;
    logic valid;
  } ex_stage_t;
  typedef struct packed {
    logic [REG_ADDR_W_DEFAULT-1:0] dst;
    logic reg_write;
  } mem_stage_t;
  typedef struct packed {
    logic [REG_ADDR_W_DEFAULT-1:0] dst;
    logic reg_write;
  } wb_stage_t;
endpackage

// File: rtl/fwd_compare.sv
// fwd_compare: prioritized forwarding select for one source specifier, newest producer first
module fwd_compare
  import mips_pipe_pkg::*;
#(
  parameter int W = REG_ADDR_W_DEFAULT
) (
  input  logic [W-1:0] src,
  input  logic         en,
  input  logic [W-1:0] mem_dst,
  input  logic         mem_we,
  input  logic [W-1:0] wb_dst,
  input  logic         wb_we,
  output logic [1:0]   sel
);
  logic mem_hit, wb_hit;
  always_comb begin
    mem_hit = en && mem_we && mem_dst != '0 && mem_dst == src;
    wb_hit = en && wb_we && wb_dst != '0 && wb_dst == src;
    sel = mem_hit ? FWD_EXMEM : wb_hit ? FWD_MEMWB : FWD_REG;
  end
endmodule

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: EX/MEM/WB dest tracking, ALU operand forwarding and load-use stall; WB_BYPASS_EN adds decode-stage WB bypass
module forward_hazard_unit
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  hold,
  input  logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_bypass_a,
  output logic                  id_bypass_b
);
  ex_stage_t ex;
  mem_stage_t mem;
  wb_stage_t wb;
  logic bubble;
  assign stall = ex.mem_read && ex.dst != '0 && id_valid && (ex.dst == id_rs || ex.dst == id_rt);
  assign pc_write = ~stall & ~hold;
  assign if_id_write = ~stall & ~hold;
  assign bubble = stall || flush || !id_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex <= '0;
      mem <= '0;
      wb <= '0;
    end else if (!hold) begin
      wb <= wb_stage_t'{dst: mem.dst, reg_write: mem.reg_write};
      mem <= mem_stage_t'{dst: ex.dst, reg_write: ex.reg_write};
      ex <= bubble ? '0 : ex_stage_t'{rs: id_rs, rt: id_rt, dst: id_dst,
                                      reg_write: id_reg_write, mem_read: id_mem_read, valid: 1'b1};
    end
  end
  fwd_compare #(.W(REG_ADDR_W)) u_cmp_a (
    .src(ex.rs), .en(ex.valid), .mem_dst(mem.dst), .mem_we(mem.reg_write),
    .wb_dst(wb.dst), .wb_we(wb.reg_write), .sel(fwd_a_sel)
  );
  fwd_compare #(.W(REG_ADDR_W)) u_cmp_b (
    .src(ex.rt), .en(ex.valid), .mem_dst(mem.dst), .mem_we(mem.reg_write),
    .wb_dst(wb.dst), .wb_we(wb.reg_write), .sel(fwd_b_sel)
  );
`ifdef WB_BYPASS_EN
  // covers a register file that cannot write before read in the same cycle
  assign id_bypass_a = wb.reg_write && wb.dst != '0 && wb.dst == id_rs;
  assign id_bypass_b = wb.reg_write && wb.dst != '0 && wb.dst == id_rt;
`else
  assign id_bypass_a = 1'b0;
  assign id_bypass_b = 1'b0;
`endif
endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb_forward_hazard_unit: directed self-checking bench for forward_hazard_unit
module tb_forward_hazard_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic [4:0] id_dst = '0;
  logic id_reg_write = 1'b0;
  logic id_mem_read = 1'b0;
  logic hold = 1'b0;
  logic flush = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic stall, pc_write, if_id_write, id_bypass_a, id_bypass_b;
  int checks = 0;
  int passes = 0;
  forward_hazard_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .hold(hold), .flush(flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_bypass_a(id_bypass_a), .id_bypass_b(id_bypass_b)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                     input logic rw, input logic mr, input logic h, input logic f);
    @(negedge clk);
    id_valid = v;
    id_rs = rs;
    id_rt = rt;
    id_dst = dst;
    id_reg_write = rw;
    id_mem_read = mr;
    hold = h;
    flush = f;
    #1;
  endtask
  task automatic nops(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_reset;
    @(negedge clk);
    #1;
    checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) $display("FAIL reset_sel: got %b required 0000", {fwd_a_sel, fwd_b_sel}); else passes++;
    checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b required 0", stall); else passes++;
    checks++; if ({pc_write, if_id_write} !== 2'b11) $display("FAIL reset_enables: got %b required 11", {pc_write, if_id_write}); else passes++;
    checks++; if ({id_bypass_a, id_bypass_b} !== 2'b00) $display("FAIL reset_bypass: got %b required 00", {id_bypass_a, id_bypass_b}); else passes++;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_back_to_back;
    nops(3);
    cyc(1, 1, 2, 3, 1, 0, 0, 0);
    cyc(1, 3, 4, 6, 1, 0, 0, 0);
    checks++; if (fwd_a_sel !== 2'b00) $display("FAIL b2b_first: got %b required 00", fwd_a_sel); else passes++;
    cyc(1, 10, 3, 7, 1, 0, 0, 0);
    checks++; if (fwd_a_sel !== 2'b01) $display("FAIL b2b_exmem_a: got %b required 01", fwd_a_sel); else passes++;
    checks++; if (fwd_b_sel !== 2'b00) $display("FAIL b2b_nohit_b: got %b required 00", fwd_b_sel); else passes++;
    nops(1);
    checks++; if (fwd_b_sel !== 2'b10) $display("FAIL b2b_memwb_b: got %b required 10", fwd_b_sel); else passes++;
    checks++; if (fwd_a_sel !== 2'b00) $display("FAIL b2b_memwb_a: got %b required 00", fwd_a_sel); else passes++;
  endtask
  task automatic test_double_producer;
    nops(3);
    cyc(1, 0, 0, 5, 1, 0, 0, 0);
    cyc(1, 0, 0, 5, 1, 0, 0, 0);
    cyc(1, 5, 0, 0, 0, 0, 0, 0);
    nops(1);
    checks++; if (fwd_a_sel !== 2'b01) $display("FAIL double_newest: got %b required 01", fwd_a_sel); else passes++;
    checks++; if (fwd_b_sel !== 2'b00) $display("FAIL double_b: got %b required 00", fwd_b_sel); else passes++;
  endtask
  task automatic test_load_use;
    nops(3);
    cyc(1, 1, 8, 8, 1, 1, 0, 0);
    cyc(1, 2, 8, 9, 1, 0, 0, 0);
    checks++; if (stall !== 1'b1) $display("FAIL lu_stall: got %b required 1", stall); else passes++;
    checks++; if ({pc_write, if_id_write} !== 2'b00) $display("FAIL lu_enables: got %b required 00", {pc_write, if_id_write}); else passes++;
    cyc(1, 2, 8, 9, 1, 0, 0, 0);
    checks++; if (stall !== 1'b0) $display("FAIL lu_one_cycle: got %b required 0", stall); else passes++;
    checks++; if ({fwd_a_sel, fwd_b_sel, pc_write} !== 5'b00001) $display("FAIL lu_bubble: got %b required 00001", {fwd_a_sel, fwd_b_sel, pc_write}); else passes++;
    nops(1);
    checks++; if (fwd_b_sel !== 2'b10) $display("FAIL lu_fwd_b: got %b required 10", fwd_b_sel); else passes++;
    checks++; if (fwd_a_sel !== 2'b00) $display("FAIL lu_fwd_a: got %b required 00", fwd_a_sel); else passes++;
  endtask
  task automatic test_reg_zero;
    nops(3);
    cyc(1, 1, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 4, 1, 0, 0, 0);
    nops(1);
    checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) $display("FAIL zero_sel: got %b required 0000", {fwd_a_sel, fwd_b_sel}); else passes++;
    cyc(1, 1, 1, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 4, 1, 0, 0, 0);
    checks++; if (stall !== 1'b0) $display("FAIL zero_stall: got %b required 0", stall); else passes++;
  endtask
  task automatic test_hold;
    nops(3);
    cyc(1, 1, 2, 3, 1, 0, 0, 0);
    cyc(1, 3, 0, 6, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
      checks++; if (fwd_a_sel !== 2'b01) $display("FAIL hold_sel[%0d]: got %b required 01", i, fwd_a_sel); else passes++;
      checks++; if ({pc_write, if_id_write} !== 2'b00) $display("FAIL hold_enables[%0d]: got %b required 00", i, {pc_write, if_id_write}); else passes++;
    end
    cyc(1, 3, 0, 7, 1, 0, 0, 0);
    checks++; if ({fwd_a_sel, pc_write} !== 3'b011) $display("FAIL hold_release: got %b required 011", {fwd_a_sel, pc_write}); else passes++;
    nops(1);
    checks++; if (fwd_a_sel !== 2'b10) $display("FAIL hold_resume: got %b required 10", fwd_a_sel); else passes++;
  endtask
  task automatic test_flush_load_use;
    nops(3);
    cyc(1, 1, 8, 8, 1, 1, 0, 0);
    cyc(1, 2, 8, 9, 1, 0, 0, 1);
    checks++; if ({stall, pc_write} !== 2'b10) $display("FAIL flush_lu: got %b required 10", {stall, pc_write}); else passes++;
    cyc(1, 2, 8, 9, 1, 0, 0, 0);
    checks++; if (stall !== 1'b0) $display("FAIL flush_no_extra: got %b required 0", stall); else passes++;
    nops(1);
    checks++; if (fwd_b_sel !== 2'b10) $display("FAIL flush_fwd_b: got %b required 10", fwd_b_sel); else passes++;
  endtask
  task automatic test_async_reset;
    nops(3);
    cyc(1, 1, 2, 3, 1, 0, 0, 0);
    cyc(1, 3, 0, 8, 1, 1, 0, 0);
    cyc(1, 0, 8, 9, 1, 0, 0, 0);
    checks++; if ({fwd_a_sel, stall} !== 3'b011) $display("FAIL ar_before: got %b required 011", {fwd_a_sel, stall}); else passes++;
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({fwd_a_sel, fwd_b_sel, stall} !== 5'b00000) $display("FAIL ar_cleared: got %b required 00000", {fwd_a_sel, fwd_b_sel, stall}); else passes++;
    checks++; if ({pc_write, if_id_write} !== 2'b11) $display("FAIL ar_enables: got %b required 11", {pc_write, if_id_write}); else passes++;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_bypass;
    nops(3);
    cyc(1, 0, 0, 9, 1, 0, 0, 0);
    nops(2);
    cyc(1, 9, 9, 1, 1, 0, 0, 0);
`ifdef WB_BYPASS_EN
    checks++; if ({id_bypass_a, id_bypass_b} !== 2'b11) $display("FAIL bypass_on: got %b required 11", {id_bypass_a, id_bypass_b}); else passes++;
`else
    checks++; if ({id_bypass_a, id_bypass_b} !== 2'b00) $display("FAIL bypass_off: got %b required 00", {id_bypass_a, id_bypass_b}); else passes++;
`endif
    cyc(1, 9, 2, 1, 1, 0, 0, 0);
    checks++; if (id_bypass_a !== 1'b0) $display("FAIL bypass_gone: got %b required 0", id_bypass_a); else passes++;
  endtask
  initial begin
    test_reset;
    test_back_to_back;
    test_double_producer;
    test_load_use;
    test_reg_zero;
    test_hold;
    test_flush_load_use;
    test_async_reset;
    test_bypass;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
